// File: rtl/seq_shift_unit_x32_pkg.sv
// rtl/seq_shift_unit_x32_pkg.sv - opcodes, FSM encoding and bit-reversal helper for the shifter
package seq_shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic [31:0] reverse32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

endpackage

// File: rtl/seq_shift_unit_x32_if.sv
// rtl/seq_shift_unit_x32_if.sv - issue/writeback handshake bundle for the shifter
interface seq_shift_unit_x32_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_op;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_op, in_data, in_shamt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_op, in_data, in_shamt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/seq_shift_unit_x32_shr_step.sv
// rtl/seq_shift_unit_x32_shr_step.sv - combinational right shift by k with a programmable fill bit
module shr_step #(
  parameter int WIDTH = 32,
  parameter int K_W   = 3
) (
  input  logic [WIDTH-1:0] data,
  input  logic [K_W-1:0]   k,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  // Shifting the complement and inverting back gives a ones fill without a sign-extension mux.
  assign result = fill ? ~((~data) >> k) : (data >> k);

endmodule

// File: rtl/seq_shift_unit_x32.sv
// rtl/seq_shift_unit_x32.sv - multi-cycle SLL/SRL/SRA unit built on a single right-shift datapath
module seq_shift_unit_x32
  import seq_shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_shift_unit_x32_if.slave  bus
);

  localparam int K_W = $clog2(STEP + 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   data;
  logic [WIDTH-1:0]   data_shr;
  logic [1:0]         op;
  logic               fill;
  logic [SHAMT_W-1:0] rem;
  logic [SHAMT_W-1:0] rem_nxt;
  logic [SHAMT_W:0]   k_full;
  logic [K_W-1:0]     k;
  logic               accept;

  assign accept = (state == S_IDLE) && bus.in_valid;

  always_comb begin
    k_full = {1'b0, rem};
    if (k_full > (SHAMT_W+1)'(STEP)) k_full = (SHAMT_W+1)'(STEP);
  end

  assign k       = K_W'(k_full);
  assign rem_nxt = rem - SHAMT_W'(k_full);

  shr_step #(
    .WIDTH (WIDTH),
    .K_W   (K_W)
  ) u_shr_step (
    .data   (data),
    .k      (k),
    .fill   (fill),
    .result (data_shr)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Reserved opcode is folded into SRL at load so only SLL needs special handling on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      op   <= '0;
      fill <= 1'b0;
      rem  <= '0;
    end else if (accept) begin
      data <= (bus.in_op == OP_SLL) ? reverse32(bus.in_data) : bus.in_data;
      op   <= ((bus.in_op == OP_SLL) || (bus.in_op == OP_SRA)) ? bus.in_op : OP_SRL;
      fill <= (bus.in_op == OP_SRA) && bus.in_data[WIDTH-1];
      rem  <= bus.in_shamt;
    end else if (state == S_SHIFT) begin
      data <= data_shr;
      rem  <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.in_valid) state_nxt = (bus.in_shamt != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (rem_nxt == '0) state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
    bus.out_data  = '0;
    if (state == S_DONE) bus.out_data = (op == OP_SLL) ? reverse32(data) : data;
  end

endmodule

// File: tb/tb_seq_shift_unit_x32.sv
// tb/tb_seq_shift_unit_x32.sv - randomized self-checking bench for seq_shift_unit_x32
module tb_seq_shift_unit_x32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seq_shift_unit_x32_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  seq_shift_unit_x32 #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] d, input int sh);
    logic signed [31:0] s;
    s = d;
    case (op)
      2'b00:   return d << sh;
      2'b11:   return s >>> sh;
      default: return d >> sh;
    endcase
  endfunction

  function automatic int ref_latency(input int sh);
    return 1 + (sh + 3) / 4;
  endfunction

  // Called at a negedge; accepts on the following posedge and then scrambles the inputs.
  task automatic start_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
    check("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    bus.in_shamt = sh;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_op    = 2'($urandom);
    bus.in_data  = $urandom;
    bus.in_shamt = 5'($urandom);
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp, input int lat);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = bus.out_valid;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_data"}, bus.out_data, exp);
    check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_idle_data"}, 32'({bus.out_valid, bus.out_data}), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh, input int hold);
    logic [31:0] exp;
    exp = ref_result(op, d, int'(sh));
    start_op(op, d, sh);
    wait_result(tag, exp, ref_latency(int'(sh)));
    repeat (hold) begin
      @(negedge clk);
      check({tag, "_held"}, bus.out_data, exp);
    end
    release_result(tag);
  endtask

  initial begin
    logic [31:0] held;
    int          stale;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data", bus.out_data, 32'd0);

    run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 0);
    run_op("sra4", 2'b11, 32'h8000_0000, 5'd4, 0);
    run_op("srl4", 2'b01, 32'h8000_0000, 5'd4, 0);
    run_op("srl0", 2'b01, 32'hDEAD_BEEF, 5'd0, 0);
    run_op("rsv8", 2'b10, 32'hF000_000F, 5'd8, 0);
    run_op("sra5", 2'b11, 32'h8765_4321, 5'd5, 1);
    run_op("sll0", 2'b00, 32'h1234_5678, 5'd0, 0);

    // Backpressure with a competing request waiting on in_ready
    start_op(2'b01, 32'hCAFE_F00D, 5'd12);
    wait_result("bp", 32'h000C_AFEF, 4);
    held = bus.out_data;
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b00;
    bus.in_data  = 32'h0000_00FF;
    bus.in_shamt = 5'd4;
    repeat (5) begin
      @(negedge clk);
      check("bp_stable", bus.out_data, held);
      check("bp_not_ready", 32'({bus.in_ready, bus.out_valid}), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    start_op(2'b00, 32'h0000_00FF, 5'd4);
    wait_result("bp_next", 32'h0000_0FF0, 2);
    release_result("bp_next");

    // Reset mid-SHIFT of a long SLL
    start_op(2'b00, 32'h0000_0001, 5'd31);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_data", bus.out_data, 32'd0);
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("abort_no_stale", 32'(stale), 32'd0);
    run_op("after_abort", 2'b11, 32'hF0F0_0000, 5'd9, 0);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
